// File: rtl/register_file.sv
// RV32I integer register file: x1..x31 in flops, x0 reads as zero,
// two combinational read ports and one write port with optional same-cycle bypass.
module register_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter bit WRITE_BYPASS = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] rs1_address,
  input  logic [ADDR_WIDTH-1:0] rs2_address,
  output logic [DATA_WIDTH-1:0] rs1,
  output logic [DATA_WIDTH-1:0] rs2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] x_reg [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] read_view [DEPTH];
  logic [DEPTH-1:0]      write_select;
  logic                  write_active;
  logic [DATA_WIDTH-1:0] rs1_stored;
  logic [DATA_WIDTH-1:0] rs2_stored;

  // A write to x0 is dropped here, so x0 needs neither storage nor bypass.
  assign write_active = write_enable && (write_address != '0);

  assign read_view[0]    = '0;
  assign write_select[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
      assign write_select[gi] = write_active && (write_address == ADDR_WIDTH'(gi));

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          x_reg[gi] <= '0;
        end else if (write_select[gi]) begin
          x_reg[gi] <= write_data;
        end
      end

      assign read_view[gi] = x_reg[gi];
    end
  endgenerate

  assign rs1_stored = read_view[rs1_address];
  assign rs2_stored = read_view[rs2_address];

  generate
    if (WRITE_BYPASS) begin : g_bypass
      always_comb begin
        rs1 = rs1_stored;
        rs2 = rs2_stored;
        if (write_active && (rs1_address == write_address)) begin
          rs1 = write_data;
        end
        if (write_active && (rs2_address == write_address)) begin
          rs2 = write_data;
        end
      end
    end else begin : g_no_bypass
      assign rs1 = rs1_stored;
      assign rs2 = rs2_stored;
    end
  endgenerate

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; runs a plain and a bypass instance side by side
// on shared inputs so both read behaviours are checked against the same stimulus.
module tb_register_file;

  logic        clk_i;
  logic        reset_i;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rs1_byp;
  logic [31:0] rs2_byp;

  int total = 0;
  int bad   = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b0)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .rs1_address   (rs1_address),
    .rs2_address   (rs2_address),
    .rs1           (rs1),
    .rs2           (rs2)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b1)) dut_byp (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .rs1_address   (rs1_address),
    .rs2_address   (rs2_address),
    .rs1           (rs1_byp),
    .rs2           (rs2_byp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive on the falling edge, capture on the rising edge, return 1 time unit later.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    write_enable  = 1'b1;
    write_address = addr;
    write_data    = data;
    @(posedge clk_i);
    #1;
    write_enable  = 1'b0;
    $display("wr x%0d <= %08h", addr, data);
  endtask

  task automatic test_reset;
    write_reg(5'd5, 32'hDEADBEEF);
    @(negedge clk_i);
    rs1_address = 5'd5;
    #1;
    total++;
    if (rs1 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL reset_preload rs1=%08h want=%08h", rs1, 32'hDEADBEEF);
    end
    reset_i = 1'b0;
    #1;
    total++;
    if (rs1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_async rs1=%08h want=%08h", rs1, 32'h0);
    end
    total++;
    if (rs1_byp !== 32'h0) begin
      bad++;
      $display("FAIL reset_async_byp rs1=%08h want=%08h", rs1_byp, 32'h0);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs1_address = 5'(a);
      rs2_address = 5'(31 - a);
      #1;
      total++;
      if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
        bad++;
        $display("FAIL reset_all addr=%0d rs1=%08h rs2=%08h want=0", a, rs1, rs2);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    @(negedge clk_i);
    write_enable  = 1'b1;
    write_address = 5'd3;
    write_data    = 32'h12345678;
    @(negedge clk_i);
    write_address = 5'd31;
    write_data    = 32'hFFFFFFFF;
    @(negedge clk_i);
    write_enable  = 1'b0;
    rs1_address   = 5'd3;
    rs2_address   = 5'd31;
    #1;
    total++;
    if (rs1 !== 32'h12345678) begin
      bad++;
      $display("FAIL basic_rs1 rs1=%08h want=%08h", rs1, 32'h12345678);
    end
    total++;
    if (rs2 !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL basic_rs2 rs2=%08h want=%08h", rs2, 32'hFFFFFFFF);
    end
    $display("test_basic done");
  endtask

  task automatic test_x0;
    @(negedge clk_i);
    write_enable  = 1'b1;
    write_address = 5'd0;
    write_data    = 32'hA5A5A5A5;
    rs1_address   = 5'd0;
    rs2_address   = 5'd0;
    #1;
    total++;
    if (rs1_byp !== 32'h0) begin
      bad++;
      $display("FAIL x0_no_bypass rs1=%08h want=%08h", rs1_byp, 32'h0);
    end
    @(posedge clk_i);
    #1;
    write_enable = 1'b0;
    total++;
    if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
      bad++;
      $display("FAIL x0_write rs1=%08h rs2=%08h want=0", rs1, rs2);
    end
    total++;
    if (rs1_byp !== 32'h0 || rs2_byp !== 32'h0) begin
      bad++;
      $display("FAIL x0_write_byp rs1=%08h rs2=%08h want=0", rs1_byp, rs2_byp);
    end
    $display("test_x0 done");
  endtask

  task automatic test_enable;
    write_reg(5'd7, 32'h00001234);
    @(negedge clk_i);
    write_enable  = 1'b0;
    write_address = 5'd7;
    write_data    = 32'h00000055;
    rs1_address   = 5'd7;
    #1;
    total++;
    if (rs1_byp !== 32'h00001234) begin
      bad++;
      $display("FAIL enable_no_bypass rs1=%08h want=%08h", rs1_byp, 32'h00001234);
    end
    @(posedge clk_i);
    #1;
    total++;
    if (rs1 !== 32'h00001234) begin
      bad++;
      $display("FAIL enable_gate rs1=%08h want=%08h", rs1, 32'h00001234);
    end
    $display("test_enable done");
  endtask

  task automatic test_same_cycle;
    write_reg(5'd9, 32'h1);
    @(negedge clk_i);
    write_enable  = 1'b1;
    write_address = 5'd9;
    write_data    = 32'h2;
    rs1_address   = 5'd9;
    rs2_address   = 5'd9;
    #1;
    total++;
    if (rs1 !== 32'h1) begin
      bad++;
      $display("FAIL same_pre_nobyp rs1=%08h want=%08h", rs1, 32'h1);
    end
    total++;
    if (rs1_byp !== 32'h2 || rs2_byp !== 32'h2) begin
      bad++;
      $display("FAIL same_pre_byp rs1=%08h rs2=%08h want=%08h", rs1_byp, rs2_byp, 32'h2);
    end
    @(posedge clk_i);
    #1;
    write_enable = 1'b0;
    total++;
    if (rs1 !== 32'h2) begin
      bad++;
      $display("FAIL same_post rs1=%08h want=%08h", rs1, 32'h2);
    end
    $display("test_same_cycle done");
  endtask

  task automatic test_dual_reset;
    write_reg(5'd12, 32'h0000005A);
    @(negedge clk_i);
    rs1_address = 5'd12;
    rs2_address = 5'd12;
    #1;
    total++;
    if (rs1 !== 32'h5A || rs2 !== 32'h5A) begin
      bad++;
      $display("FAIL dual_read rs1=%08h rs2=%08h want=%08h", rs1, rs2, 32'h5A);
    end
    @(negedge clk_i);
    write_enable  = 1'b1;
    write_address = 5'd12;
    write_data    = 32'h77;
    #2;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    write_enable = 1'b0;
    reset_i      = 1'b1;
    #1;
    total++;
    if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_write rs1=%08h rs2=%08h want=0", rs1, rs2);
    end
    $display("test_dual_reset done");
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    vals[0] = 32'h11110001;
    vals[1] = 32'h22220002;
    vals[2] = 32'h33330003;
    vals[3] = 32'h44440004;
    @(negedge clk_i);
    write_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write_address = 5'(i + 1);
      write_data    = vals[i];
      @(negedge clk_i);
    end
    write_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs1_address = 5'(i + 1);
      rs2_address = 5'(4 - i);
      #1;
      total++;
      if (rs1 !== vals[i] || rs2 !== vals[3 - i]) begin
        bad++;
        $display("FAIL b2b idx=%0d rs1=%08h rs2=%08h want=%08h/%08h",
                 i, rs1, rs2, vals[i], vals[3 - i]);
      end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    reset_i       = 1'b0;
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    rs1_address   = '0;
    rs2_address   = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;

    test_reset();
    test_basic();
    test_x0();
    test_enable();
    test_same_cycle();
    test_dual_reset();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
